// File: rtl/nrisc_ula_bist.sv
// Built-in self test for the nRISC ULA: drives LFSR operands through ten fixed
// operations, compares each ULA result with an internal golden model, and reports the outcome.
module nrisc_ula_bist #(
  parameter int TAM        = 16,
  parameter int VEC_PER_OP = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [TAM-1:0] ULA_A,
  output logic [TAM-1:0] ULA_B,
  output logic [3:0]     ULA_ctrl,
  output logic           incdec,
  output logic           cmp2,
  input  logic [TAM-1:0] ULA_OUT,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [7:0]     err_count,
  output logic [3:0]     first_err_op
);

  localparam logic [TAM-1:0] SEED_A   = TAM'(16'hACE1);
  localparam logic [TAM-1:0] SEED_B   = TAM'(16'h1D0F);
  localparam logic [7:0]     LAST_VEC = 8'(VEC_PER_OP - 1);
  localparam logic [3:0]     LAST_OP  = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK, S_DONE} state_t;

  state_t         state_q;
  logic [TAM-1:0] lfsr_a_q, lfsr_b_q;
  logic [TAM-1:0] ula_a_q, ula_b_q, golden_q;
  logic [3:0]     ula_ctrl_q, op_idx_q, first_err_op_q;
  logic [7:0]     vec_cnt_q, err_count_q;
  logic           busy_q, done_q, pass_q;

  logic [TAM-1:0] lfsr_a_nx_s, lfsr_b_nx_s, load_a_s, load_b_s, golden_s;
  logic [3:0]     op_idx_d, load_ctrl_s, first_err_op_d;
  logic [7:0]     vec_cnt_d, err_count_d;
  logic           launch_s, mismatch_s, last_vec_s, final_vec_s;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting toward the MSB.
  function automatic logic [TAM-1:0] lfsr_step(input logic [TAM-1:0] s);
    return {s[TAM-2:0], s[TAM-1] ^ s[TAM-3] ^ s[TAM-4] ^ s[TAM-6]};
  endfunction

  function automatic logic [3:0] op_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'b0000;
      4'd1:    return 4'b0001;
      4'd2:    return 4'b0010;
      4'd3:    return 4'b0011;
      4'd4:    return 4'b0100;
      4'd5:    return 4'b0101;
      4'd6:    return 4'b1101;
      4'd7:    return 4'b0110;
      4'd8:    return 4'b1110;
      4'd9:    return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [TAM-1:0] golden(input logic [TAM-1:0] a, input logic [TAM-1:0] b,
                                            input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return {1'b0, a[TAM-1:1]};
      4'b1101: return {a[0], a[TAM-1:1]};
      4'b0110: return {a[TAM-2:0], 1'b0};
      4'b1110: return {a[TAM-2:0], a[TAM-1]};
      4'b0111: return ~a;
      default: return '0;
    endcase
  endfunction

  // Sequencing, comparison and next-vector operand selection.
  always_comb begin
    lfsr_a_nx_s = lfsr_step(lfsr_a_q);
    lfsr_b_nx_s = lfsr_step(lfsr_b_q);
    launch_s    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    last_vec_s  = (vec_cnt_q == LAST_VEC);
    final_vec_s = last_vec_s && (op_idx_q == LAST_OP);
    mismatch_s  = (ULA_OUT != golden_q);

    if (last_vec_s) begin
      vec_cnt_d = 8'd0;
      op_idx_d  = op_idx_q + 4'd1;
    end else begin
      vec_cnt_d = vec_cnt_q + 8'd1;
      op_idx_d  = op_idx_q;
    end

    if (mismatch_s && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end

    if (mismatch_s && (err_count_q == 8'd0)) begin
      first_err_op_d = ula_ctrl_q;
    end else begin
      first_err_op_d = first_err_op_q;
    end

    // A launch restarts from the seeds; otherwise the next vector uses the advanced LFSRs.
    if (launch_s) begin
      load_a_s    = SEED_A;
      load_b_s    = SEED_B;
      load_ctrl_s = op_code(4'd0);
    end else begin
      load_a_s    = lfsr_a_nx_s;
      load_b_s    = lfsr_b_nx_s;
      load_ctrl_s = op_code(op_idx_d);
    end
    golden_s = golden(load_a_s, load_b_s, load_ctrl_s);
  end

  // Controller state, operand registers and result bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      lfsr_a_q       <= SEED_A;
      lfsr_b_q       <= SEED_B;
      ula_a_q        <= '0;
      ula_b_q        <= '0;
      ula_ctrl_q     <= 4'd0;
      golden_q       <= '0;
      op_idx_q       <= 4'd0;
      vec_cnt_q      <= 8'd0;
      err_count_q    <= 8'd0;
      first_err_op_q <= 4'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else if (launch_s) begin
      state_q        <= S_ISSUE;
      lfsr_a_q       <= SEED_A;
      lfsr_b_q       <= SEED_B;
      ula_a_q        <= load_a_s;
      ula_b_q        <= load_b_s;
      ula_ctrl_q     <= load_ctrl_s;
      golden_q       <= golden_s;
      op_idx_q       <= 4'd0;
      vec_cnt_q      <= 8'd0;
      err_count_q    <= 8'd0;
      first_err_op_q <= 4'd0;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      case (state_q)
        S_ISSUE: state_q <= S_CHECK;
        S_CHECK: begin
          err_count_q    <= err_count_d;
          first_err_op_q <= first_err_op_d;
          if (final_vec_s) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == 8'd0);
          end else begin
            state_q    <= S_ISSUE;
            lfsr_a_q   <= lfsr_a_nx_s;
            lfsr_b_q   <= lfsr_b_nx_s;
            ula_a_q    <= load_a_s;
            ula_b_q    <= load_b_s;
            ula_ctrl_q <= load_ctrl_s;
            golden_q   <= golden_s;
            vec_cnt_q  <= vec_cnt_d;
            op_idx_q   <= op_idx_d;
          end
        end
        S_IDLE:  state_q <= S_IDLE;
        S_DONE:  state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ULA_A        = ula_a_q;
  assign ULA_B        = ula_b_q;
  assign ULA_ctrl     = ula_ctrl_q;
  assign incdec       = 1'b0;
  assign cmp2         = 1'b0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_count_q;
  assign first_err_op = first_err_op_q;

endmodule

// File: tb/tb_nrisc_ula_bist.sv
// Bench for nrisc_ula_bist: a behavioural ULA (optionally faulted) answers the DUT,
// and a vector-list reference model predicts operands, timing and error reporting.
module tb_nrisc_ula_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start32;
  logic [15:0] ula_a, ula_b, ula_out;
  logic [3:0]  ula_ctrl, first_err_op;
  logic        incdec, cmp2, busy, done, pass;
  logic [7:0]  err_count;

  logic [15:0] a32, b32, zero32;
  logic [3:0]  ctrl32, first32;
  logic        incdec32, cmp232, busy32, done32, pass32;
  logic [7:0]  err32;

  int fault_mode;
  int checks = 0;
  int errors = 0;

  logic [3:0] op_list [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                               4'b0101, 4'b1101, 4'b0110, 4'b1110, 4'b0111};
  logic [15:0] va [320];
  logic [15:0] vb [320];

  nrisc_ula_bist #(.TAM(16), .VEC_PER_OP(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ULA_A(ula_a), .ULA_B(ula_b),
    .ULA_ctrl(ula_ctrl), .incdec(incdec), .cmp2(cmp2), .ULA_OUT(ula_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_op(first_err_op));

  nrisc_ula_bist #(.TAM(16), .VEC_PER_OP(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .ULA_A(a32), .ULA_B(b32),
    .ULA_ctrl(ctrl32), .incdec(incdec32), .cmp2(cmp232), .ULA_OUT(zero32),
    .busy(busy32), .done(done32), .pass(pass32), .err_count(err32),
    .first_err_op(first32));

  assign zero32 = 16'h0000;

  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] code);
    case (code)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return a / 16'd2;
      4'b1101: return (a >> 1) | (a << 15);
      4'b0110: return a * 16'd2;
      4'b1110: return (a << 1) | (a >> 15);
      4'b0111: return 16'hFFFF - a;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  always_comb begin
    ula_out = ref_alu(ula_a, ula_b, ula_ctrl);
    if (fault_mode == 1) ula_out = ula_out & 16'hFFFE;
    else if (fault_mode == 2) ula_out = 16'h0000;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_outcome(input int nvec, input int vpo, input int mode,
                                output logic [7:0] e_err, output logic [3:0] e_first);
    logic [15:0] g, o;
    logic [3:0]  op;
    e_err = 8'd0;
    e_first = 4'd0;
    for (int k = 0; k < nvec; k++) begin
      op = op_list[k / vpo];
      g  = ref_alu(va[k], vb[k], op);
      o  = (mode == 2) ? 16'h0000 : ((mode == 1) ? (g & 16'hFFFE) : g);
      if (o != g) begin
        if (e_err == 8'd0) e_first = op;
        if (e_err != 8'd255) e_err = e_err + 8'd1;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_a"}, 32'(ula_a), 32'h0);
    check_val({tag, "_b"}, 32'(ula_b), 32'h0);
    check_val({tag, "_ctrl"}, 32'(ula_ctrl), 32'h0);
    check_val({tag, "_busy"}, 32'(busy), 32'h0);
    check_val({tag, "_done"}, 32'(done), 32'h0);
    check_val({tag, "_pass"}, 32'(pass), 32'h0);
    check_val({tag, "_err"}, 32'(err_count), 32'h0);
    check_val({tag, "_first"}, 32'(first_err_op), 32'h0);
  endtask

  // One complete 160-vector run on the VEC_PER_OP=16 instance, cycle by cycle.
  task automatic run16(input string tag, input bit hold);
    logic [7:0] e_err;
    logic [3:0] e_first;
    expect_outcome(160, 16, fault_mode, e_err, e_first);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check_val({tag, "_busy"}, 32'(busy), 32'h1);
    check_val({tag, "_errclr"}, 32'(err_count), 32'h0);
    for (int k = 0; k < 160; k++) begin
      check_val({tag, "_opA"}, 32'(ula_a), 32'(va[k]));
      check_val({tag, "_opB"}, 32'(ula_b), 32'(vb[k]));
      check_val({tag, "_ctrl"}, 32'(ula_ctrl), 32'(op_list[k / 16]));
      @(posedge clk); #1;
      check_val({tag, "_holdA"}, 32'(ula_a), 32'(va[k]));
      check_val({tag, "_notdone"}, 32'(done), 32'h0);
      @(posedge clk); #1;
    end
    check_val({tag, "_done"}, 32'(done), 32'h1);
    check_val({tag, "_busyoff"}, 32'(busy), 32'h0);
    check_val({tag, "_pass"}, 32'(pass), 32'(e_err == 8'd0));
    check_val({tag, "_errcnt"}, 32'(err_count), 32'(e_err));
    check_val({tag, "_firstop"}, 32'(first_err_op), 32'(e_first));
    check_val({tag, "_doneA"}, 32'(ula_a), 32'(va[159]));
    start = 1'b0;
    @(posedge clk); #1;
    check_val({tag, "_donehold"}, 32'(done), 32'h1);
  endtask

  initial begin
    logic [15:0] sa, sb;
    logic [7:0]  e_err;
    logic [3:0]  e_first;
    int          cyc;

    sa = 16'hACE1;
    sb = 16'h1D0F;
    for (int k = 0; k < 320; k++) begin
      va[k] = sa;
      vb[k] = sb;
      sa = lfsr_next(sa);
      sb = lfsr_next(sb);
    end

    fault_mode = 0;
    rst = 1'b0;
    start = 1'b0;
    start32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    check_val("rst_incdec", 32'(incdec), 32'h0);
    check_val("rst_cmp2", 32'(cmp2), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("idle_busy", 32'(busy), 32'h0);

    check_val("first_gold", 32'(ref_alu(va[0], vb[0], op_list[0])), 32'hC9F0);
    run16("golden", 1'b0);

    fault_mode = 1;
    run16("stuck0", 1'b0);

    fault_mode = 0;
    run16("hold", 1'b1);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    check_val("mid_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midrst");
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_idle", 32'(busy), 32'h0);
    run16("replay", 1'b0);

    fault_mode = 2;
    expect_outcome(320, 32, 2, e_err, e_first);
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    cyc = 0;
    while (!done32 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("zero_cycles", 32'(cyc), 32'd640);
    check_val("zero_err", 32'(err32), 32'(e_err));
    check_val("zero_err255", 32'(err32), 32'd255);
    check_val("zero_first", 32'(first32), 32'(e_first));
    check_val("zero_pass", 32'(pass32), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
